// File: rtl/vga_sync_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters advanced by a
// pixel-clock enable, registered sync/display-enable/strobe outputs, and a
// frame-synchronous colour-enable handshake.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame_count
// output that counts frame_start pulses (wrapping 0xFFFF -> 0).
module vga_sync_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        rendering_finished,
  output logic        hsync,
  output logic        vsync,
  output logic        dena,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        enable_output_color
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 11 bits wide, so neither total may exceed 2048.
  if (H_TOTAL > 2048 || V_TOTAL > 2048 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_total_check
    $error("vga_sync_timing_gen: H_TOTAL/V_TOTAL must be in 1..2048");
  end

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_FP_START   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_BP_START   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // A phase start equal to the total means that phase and all later ones are
  // empty; such a boundary must never match (it would alias to count 0).
  localparam bit H_FP_OK   = (H_ACTIVE < H_TOTAL);
  localparam bit H_SYNC_OK = (H_ACTIVE + H_FP < H_TOTAL);
  localparam bit H_BP_OK   = (H_ACTIVE + H_FP + H_SYNC < H_TOTAL);
  localparam bit V_FP_OK   = (V_ACTIVE < V_TOTAL);
  localparam bit V_SYNC_OK = (V_ACTIVE + V_FP < V_TOTAL);
  localparam bit V_BP_OK   = (V_ACTIVE + V_FP + V_SYNC < V_TOTAL);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

  logic [10:0] h_cnt_reg, h_cnt_next;
  logic [10:0] v_cnt_reg, v_cnt_next;
  phase_t      h_state_reg, h_state_next;
  phase_t      v_state_reg, v_state_next;
  logic        frame_tick;
  logic        dena_reg, hsync_reg, vsync_reg;
  logic        line_start_reg, frame_start_reg, eoc_reg;

  // Next counter values: h advances per tick, v advances when h wraps.
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (pix_en) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        v_cnt_next = (v_cnt_reg == V_LAST) ? 11'd0 : v_cnt_reg + 11'd1;
      end else begin
        h_cnt_next = h_cnt_reg + 11'd1;
      end
    end
  end

  assign frame_tick = pix_en && (h_cnt_next == 11'd0) && (v_cnt_next == 11'd0);

  // Phase next-state: enter a phase when the next count hits its start.
  // Later phases are tested last so an empty phase is skipped over.
  always_comb begin
    h_state_next = h_state_reg;
    v_state_next = v_state_reg;
    if (pix_en) begin
      if (h_cnt_next == 11'd0)                    h_state_next = PH_ACTIVE;
      if (H_FP_OK   && h_cnt_next == H_FP_START)   h_state_next = PH_FP;
      if (H_SYNC_OK && h_cnt_next == H_SYNC_START) h_state_next = PH_SYNC;
      if (H_BP_OK   && h_cnt_next == H_BP_START)   h_state_next = PH_BP;
      if (v_cnt_next == 11'd0)                    v_state_next = PH_ACTIVE;
      if (V_FP_OK   && v_cnt_next == V_FP_START)   v_state_next = PH_FP;
      if (V_SYNC_OK && v_cnt_next == V_SYNC_START) v_state_next = PH_SYNC;
      if (V_BP_OK   && v_cnt_next == V_BP_START)   v_state_next = PH_BP;
    end
  end

  // Counter and phase state registers; reset parks on the last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg   <= H_LAST;
      v_cnt_reg   <= V_LAST;
      h_state_reg <= PH_BP;
      v_state_reg <= PH_BP;
    end else begin
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
      h_state_reg <= h_state_next;
      v_state_reg <= v_state_next;
    end
  end

  // Registered outputs from next-state values, so they align with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      dena_reg        <= 1'b0;
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      eoc_reg         <= 1'b0;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      if (pix_en) begin
        dena_reg        <= (h_state_next == PH_ACTIVE) && (v_state_next == PH_ACTIVE);
        hsync_reg       <= (h_state_next == PH_SYNC) ? HS_POL : ~HS_POL;
        vsync_reg       <= (v_state_next == PH_SYNC) ? VS_POL : ~VS_POL;
        line_start_reg  <= (h_cnt_next == 11'd0);
        frame_start_reg <= frame_tick;
        if (frame_tick) begin
          eoc_reg <= rendering_finished;
        end
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_reg;

  // Frame counter steps together with the frame_start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_reg <= '0;
    end else if (frame_tick) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
`endif

  assign hsync               = hsync_reg;
  assign vsync               = vsync_reg;
  assign dena                = dena_reg;
  assign pixel_x             = h_cnt_reg;
  assign pixel_y             = v_cnt_reg;
  assign line_start          = line_start_reg;
  assign frame_start         = frame_start_reg;
  assign enable_output_color = eoc_reg;

endmodule

// File: doc/vga_sync_timing_gen.md
# vga_sync_timing_gen

Generates VGA raster timing: horizontal and vertical sync, display enable (`dena`), pixel coordinates and frame/line strobes, advanced by a pixel-clock enable. It drives the `dena` and `enable_output_color` inputs of the output colour mask and the coordinate inputs of the pixel source. `enable_output_color` only changes on frame boundaries, so the display never shows a partially rendered frame.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (ticks)
- `H_SYNC`, 96, hsync pulse width (ticks)
- `H_BP`, 48, horizontal back porch (ticks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active low)
- `VS_POL`, 0, vsync active level (0 = active low)

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `pix_en` in 1: pixel tick; counters advance only on cycles with `pix_en`=1
- `rendering_finished` in 1: level from the renderer; frame is ready for display
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `dena` out 1: display enable; high in the active region
- `pixel_x` out 11: horizontal counter, `h_cnt`
- `pixel_y` out 11: vertical counter, `v_cnt`
- `line_start` out 1: one-`clk` pulse on the tick where `h_cnt` becomes 0
- `frame_start` out 1: one-`clk` pulse on the tick where (`h_cnt`,`v_cnt`) becomes (0,0)
- `enable_output_color` out 1: display-gating flag, updated only at frame start

## Operation
- `H_TOTAL`=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). `V_TOTAL` is formed the same way (default 525). Each total must be ≤2048; the elaboration fails otherwise.
- On each `pix_en` tick, `h_cnt` increments. At `H_TOTAL-1` it wraps to 0 and `v_cnt` increments. `v_cnt` wraps from `V_TOTAL-1` to 0.
- The horizontal phase FSM tracks `h_cnt`: ACTIVE [0, H_ACTIVE), FP, SYNC, BP. The vertical phase FSM follows the same pattern on `v_cnt`.
- `dena` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- `hsync` is at level `HS_POL` for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Otherwise it is at level ~`HS_POL`.
- `vsync` is at level `VS_POL` for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines. Otherwise it is at level ~`VS_POL`.
- Frame handshake: on the `frame_start` tick, `enable_output_color` <= `rendering_finished`. The value is held for the entire frame. Changes to `rendering_finished` mid-frame have no effect until the next frame start.
- `pixel_x` and `pixel_y` are meaningful as coordinates only while `dena`=1.

## Timing
- All outputs are registered. They update on the same `clk` edge as the counters, from the next-state counter values. There is zero tick of skew between the counters and `dena`, `hsync` and `vsync`.
- Reset values:
  - `h_cnt`=H_TOTAL-1, `v_cnt`=V_TOTAL-1
  - `dena`=0, `hsync`=~HS_POL, `vsync`=~VS_POL
  - `line_start`=0, `frame_start`=0, `enable_output_color`=0
- After `rst` is released, the first `pix_en` tick wraps to (0,0) with `dena`=1, `line_start`=1 and `frame_start`=1.
- When `pix_en`=0, all outputs hold and the strobes are 0. A strobe lasts exactly one `clk` cycle even when `pix_en` is held high.
- `rst` asserted mid-frame returns to the reset state on the next edge and overrides `pix_en`.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: adds output port `frame_count` out 16. The counter resets to 0, increments on each `frame_start` pulse, and wraps from 0xFFFF to 0. The first frame after reset reads 1.
- `VGA_TIMING_FRAME_CNT_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Defaults, `pix_en`=1 every cycle:
  - Release `rst`. Tick 1: `dena`=1, (0,0), `frame_start`=1.
  - `frame_start` recurs every 420000 cycles.
- Horizontal timing:
  - `hsync` is low for exactly 96 consecutive ticks, `h_cnt` 656..751.
  - `dena` falls at `h_cnt`=640.
  - `line_start` occurs every 800 ticks.
- Vertical timing:
  - `vsync` is low for exactly 1600 ticks, `v_cnt` 490..491.
  - A full frame contains 307200 `dena`=1 ticks.
- `pix_en` toggled 1/0 every cycle:
  - Outputs hold on `pix_en`=0 cycles.
  - Frame period doubles to 840000 `clk` cycles.
  - Strobes remain one cycle wide.
- Frame handshake:
  - Raise `rendering_finished` at (100,200). `enable_output_color` stays 0 until the next `frame_start`, then rises with it.
  - Drop `rendering_finished` mid-frame. `enable_output_color` falls at the following `frame_start`.
- Reset mid-frame, plus macro:
  - Assert `rst` at (300,300) with `pix_en`=1. All outputs return to their reset values on the next edge.
  - With the macro defined, `frame_count` increments 1, 2, 3 across three frames and resets to 0.
